// File: rtl/sdram_wb_protocol_monitor.sv
// Passive checker for SDRAM controller init sequencing and Wishbone slave handshakes.
// Raises sticky per-rule flags, a one-cycle error pulse and a saturating violation count.
module sdram_wb_protocol_monitor #(
  parameter int INIT_CYCLES   = 10000,
  parameter int NUM_AREF      = 2,
  parameter int PHASE_TIMEOUT = 1024,
  parameter int WB_TIMEOUT    = 256,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sdram_init_done,
  input  logic                 cs,
  input  logic                 ras,
  input  logic                 cas,
  input  logic                 we,
  input  logic                 cycle,
  input  logic                 strb,
  input  logic                 ack,
  input  logic                 err_clr,
  output logic [7:0]           err_flags,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 init_ok,
  output logic [2:0]           init_state,
  output logic [3:0]           aref_cnt
);

  localparam int MAX_CYC = (INIT_CYCLES > PHASE_TIMEOUT) ? INIT_CYCLES : PHASE_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int STALL_W = $clog2(WB_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NOPW = 3'd1,
    S_PRE  = 3'd2,
    S_AREF = 3'd3,
    S_MRS  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic               init_done_q;
  logic               first_q;
  logic               ok_nx;
  logic [3:0]         aref_nx;
  logic [7:0]         viol;
  logic               cmd_nop, cmd_pre, cmd_aref, cmd_mrs;
  logic               done_fall, done_rise, phase_to, wb_req;

  assign cmd_nop   = !cs &&  ras &&  cas &&  we;
  assign cmd_pre   = !cs && !ras &&  cas && !we;
  assign cmd_aref  = !cs && !ras && !cas &&  we;
  assign cmd_mrs   = !cs && !ras && !cas && !we;
  assign done_fall = !sdram_init_done &&  init_done_q;
  assign done_rise =  sdram_init_done && !init_done_q;
  assign phase_to  = (cnt == CNT_W'(PHASE_TIMEOUT - 1));
  assign wb_req    = cycle && strb;
  assign init_state = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Phase sequencing plus all per-cycle rule evaluation
  always_comb begin
    state_nx = state;
    ok_nx    = init_ok;
    aref_nx  = aref_cnt;
    viol     = '0;
    if (state == S_AREF && cmd_aref && aref_cnt != 4'hF) aref_nx = aref_cnt + 4'd1;
    case (state)
      S_IDLE, S_DONE: begin
        if (done_fall) begin
          state_nx = S_NOPW;
          aref_nx  = '0;
          ok_nx    = 1'b0;
        end
      end
      S_NOPW: begin
        if (!cs && !cmd_nop) viol[0] = 1'b1;
        if (done_rise) begin
          viol[1]  = 1'b1;
          state_nx = S_DONE;
          ok_nx    = 1'b0;
        end else if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
          state_nx = S_PRE;
        end
      end
      S_PRE: begin
        if (done_rise) begin
          viol[1]  = 1'b1;
          state_nx = S_DONE;
          ok_nx    = 1'b0;
        end else if (cmd_pre) begin
          state_nx = S_AREF;
        end else if (phase_to) begin
          viol[2]  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_AREF: begin
        if (done_rise) begin
          viol[1]  = 1'b1;
          state_nx = S_DONE;
          ok_nx    = 1'b0;
        end else if (cmd_mrs) begin
          if (aref_cnt < 4'(NUM_AREF)) viol[3] = 1'b1;
          state_nx = S_MRS;
        end else if (phase_to) begin
          viol[2]  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_MRS: begin
        if (done_rise) begin
          state_nx = S_DONE;
          ok_nx    = (err_flags[3:0] == 4'h0);
        end else if (phase_to) begin
          viol[2]  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    viol[4] = strb && !cycle;
    viol[5] = ack && !wb_req;
    viol[6] = first_q && (cycle || strb);
    viol[7] = wb_req && !ack && (stall_cnt == STALL_W'(WB_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      stall_cnt   <= '0;
      aref_cnt    <= '0;
      init_ok     <= 1'b0;
      init_done_q <= 1'b1;
      first_q     <= 1'b1;
      err_flags   <= '0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      init_done_q <= sdram_init_done;
      first_q     <= 1'b0;
      aref_cnt    <= aref_nx;
      init_ok     <= ok_nx;
      if (state_nx != state || state == S_IDLE || state == S_DONE) cnt <= '0;
      else                                                         cnt <= cnt + CNT_W'(1);
      // Stall counter parks at the limit so a hung request reports only once
      if (wb_req && !ack) begin
        if (stall_cnt != STALL_W'(WB_TIMEOUT)) stall_cnt <= stall_cnt + STALL_W'(1);
      end else begin
        stall_cnt <= '0;
      end
      err_pulse <= |viol;
      if (err_clr) begin
        err_flags <= viol;
        err_count <= (|viol) ? ERR_CNT_W'(1) : '0;
      end else begin
        err_flags <= err_flags | viol;
        if ((|viol) && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdram_wb_protocol_monitor.sv
// Directed bench for sdram_wb_protocol_monitor with INIT_CYCLES shortened to 100.
module tb_sdram_wb_protocol_monitor;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_MRS  = 4'b0000;

  logic       clk = 1'b0;
  logic       rst, sdram_init_done, cs, ras, cas, we, cycle, strb, ack, err_clr;
  logic [7:0] err_flags;
  logic       err_pulse, init_ok;
  logic [7:0] err_count;
  logic [2:0] init_state;
  logic [3:0] aref_cnt;
  int checks = 0;
  int errors = 0;

  sdram_wb_protocol_monitor #(
    .INIT_CYCLES(100), .NUM_AREF(2), .PHASE_TIMEOUT(1024), .WB_TIMEOUT(256), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .sdram_init_done(sdram_init_done),
    .cs(cs), .ras(ras), .cas(cas), .we(we),
    .cycle(cycle), .strb(strb), .ack(ack), .err_clr(err_clr),
    .err_flags(err_flags), .err_pulse(err_pulse), .err_count(err_count),
    .init_ok(init_ok), .init_state(init_state), .aref_cnt(aref_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] c);
    {cs, ras, cas, we} = c;
  endtask

  task automatic do_reset();
    rst = 1'b0; sdram_init_done = 1'b1; drive_cmd(C_NOP);
    cycle = 1'b0; strb = 1'b0; ack = 1'b0; err_clr = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Fall of init_done plus 100 NOPW cycles: 101 edges leave the FSM in PRE
  task automatic run_to_pre();
    sdram_init_done = 1'b0; drive_cmd(C_NOP);
    repeat (101) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (err_flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h exp 00", err_flags); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b exp 0", err_pulse); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", err_count); end
    checks++; if (init_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", init_state); end
    checks++; if (init_ok !== 1'b0 || aref_cnt !== 4'd0) begin errors++; $display("FAIL reset_ok_aref: got %b/%0d exp 0/0", init_ok, aref_cnt); end
  endtask

  task automatic test_legal_init();
    do_reset();
    run_to_pre();
    checks++; if (init_state !== 3'd2) begin errors++; $display("FAIL legal_pre_state: got %0d exp 2", init_state); end
    drive_cmd(C_PRE); tick();
    checks++; if (init_state !== 3'd3) begin errors++; $display("FAIL legal_aref_state: got %0d exp 3", init_state); end
    drive_cmd(C_AREF); tick(); tick();
    drive_cmd(C_MRS); tick();
    checks++; if (init_state !== 3'd4) begin errors++; $display("FAIL legal_mrs_state: got %0d exp 4", init_state); end
    drive_cmd(C_NOP); sdram_init_done = 1'b1; tick();
    checks++; if (init_state !== 3'd5) begin errors++; $display("FAIL legal_done_state: got %0d exp 5", init_state); end
    checks++; if (init_ok !== 1'b1) begin errors++; $display("FAIL legal_init_ok: got %b exp 1", init_ok); end
    checks++; if (aref_cnt !== 4'd2) begin errors++; $display("FAIL legal_aref_cnt: got %0d exp 2", aref_cnt); end
    checks++; if (err_flags !== 8'h00 || err_count !== 8'd0) begin errors++; $display("FAIL legal_errs: got %h/%0d exp 00/0", err_flags, err_count); end
    sdram_init_done = 1'b0; tick();
    checks++; if (init_state !== 3'd1 || init_ok !== 1'b0 || aref_cnt !== 4'd0) begin
      errors++; $display("FAIL legal_rearm: got st=%0d ok=%b aref=%0d exp 1/0/0", init_state, init_ok, aref_cnt);
    end
  endtask

  task automatic test_init_cmd();
    do_reset();
    sdram_init_done = 1'b0; drive_cmd(C_NOP);
    repeat (51) tick();
    drive_cmd(C_PRE); tick();
    checks++; if (err_flags !== 8'h01) begin errors++; $display("FAIL initcmd_flags: got %h exp 01", err_flags); end
    checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL initcmd_pulse_cnt: got %b/%0d exp 1/1", err_pulse, err_count); end
    drive_cmd(C_NOP); tick();
    checks++; if (err_pulse !== 1'b0 || init_state !== 3'd1) begin errors++; $display("FAIL initcmd_after: got pulse=%b st=%0d exp 0/1", err_pulse, init_state); end
    repeat (48) tick();
    checks++; if (init_state !== 3'd2) begin errors++; $display("FAIL initcmd_pre_state: got %0d exp 2", init_state); end
    drive_cmd(C_PRE); tick();
    drive_cmd(C_AREF); tick(); tick();
    drive_cmd(C_MRS); tick();
    drive_cmd(C_NOP); sdram_init_done = 1'b1; tick();
    checks++; if (init_state !== 3'd5 || init_ok !== 1'b0) begin errors++; $display("FAIL initcmd_done: got st=%0d ok=%b exp 5/0", init_state, init_ok); end
  endtask

  task automatic test_aref_short();
    do_reset();
    run_to_pre();
    drive_cmd(C_PRE); tick();
    drive_cmd(C_AREF); tick();
    drive_cmd(C_MRS); tick();
    checks++; if (err_flags !== 8'h08 || err_pulse !== 1'b1) begin errors++; $display("FAIL aref_short: got %h/%b exp 08/1", err_flags, err_pulse); end
    drive_cmd(C_NOP); sdram_init_done = 1'b1; tick();
    checks++; if (init_state !== 3'd5 || init_ok !== 1'b0) begin errors++; $display("FAIL aref_short_done: got st=%0d ok=%b exp 5/0", init_state, init_ok); end
  endtask

  task automatic test_phase_timeout();
    do_reset();
    run_to_pre();
    repeat (1023) tick();
    checks++; if (init_state !== 3'd2 || err_flags !== 8'h00) begin errors++; $display("FAIL timeout_early: got st=%0d flags=%h exp 2/00", init_state, err_flags); end
    tick();
    checks++; if (init_state !== 3'd0 || err_flags !== 8'h04) begin errors++; $display("FAIL timeout: got st=%0d flags=%h exp 0/04", init_state, err_flags); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_count: got %0d exp 1", err_count); end
  endtask

  task automatic test_early_done();
    do_reset();
    sdram_init_done = 1'b0; repeat (10) tick();
    sdram_init_done = 1'b1; tick();
    checks++; if (init_state !== 3'd5 || err_flags !== 8'h02 || init_ok !== 1'b0) begin
      errors++; $display("FAIL early_done: got st=%0d flags=%h ok=%b exp 5/02/0", init_state, err_flags, init_ok);
    end
  endtask

  task automatic test_wishbone();
    do_reset();
    tick();
    strb = 1'b1; tick();
    checks++; if (err_flags !== 8'h10 || err_pulse !== 1'b1) begin errors++; $display("FAIL wb_stb_no_cyc: got %h/%b exp 10/1", err_flags, err_pulse); end
    strb = 1'b0; cycle = 1'b1; ack = 1'b1; tick();
    checks++; if (err_flags !== 8'h30) begin errors++; $display("FAIL wb_ack_no_req: got %h exp 30", err_flags); end
    strb = 1'b1; ack = 1'b0;
    repeat (255) tick();
    checks++; if (err_flags !== 8'h30 || err_count !== 8'd2) begin errors++; $display("FAIL wb_stall_early: got %h/%0d exp 30/2", err_flags, err_count); end
    tick();
    checks++; if (err_flags !== 8'hB0 || err_count !== 8'd3) begin errors++; $display("FAIL wb_stall: got %h/%0d exp b0/3", err_flags, err_count); end
    repeat (10) tick();
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL wb_stall_hold: got %0d exp 3", err_count); end
    cycle = 1'b0; strb = 1'b0;
  endtask

  task automatic test_rst_idle_and_clear();
    do_reset();
    cycle = 1'b1; tick();
    checks++; if (err_flags !== 8'h40 || err_count !== 8'd1) begin errors++; $display("FAIL rst_idle: got %h/%0d exp 40/1", err_flags, err_count); end
    cycle = 1'b0; err_clr = 1'b1; tick();
    checks++; if (err_flags !== 8'h00 || err_count !== 8'd0) begin errors++; $display("FAIL clr_alone: got %h/%0d exp 00/0", err_flags, err_count); end
    strb = 1'b1; tick();
    checks++; if (err_flags !== 8'h10 || err_count !== 8'd1) begin errors++; $display("FAIL clr_with_viol: got %h/%0d exp 10/1", err_flags, err_count); end
    strb = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_aref();
    do_reset();
    run_to_pre();
    drive_cmd(C_PRE); tick();
    drive_cmd(C_AREF); tick();
    drive_cmd(C_NOP);
    checks++; if (aref_cnt !== 4'd1 || init_state !== 3'd3) begin errors++; $display("FAIL mid_aref_pre: got aref=%0d st=%0d exp 1/3", aref_cnt, init_state); end
    rst = 1'b0; tick();
    checks++; if ({err_flags, err_pulse, err_count, init_ok, init_state, aref_cnt} !== 25'd0) begin
      errors++; $display("FAIL mid_reset: got st=%0d aref=%0d flags=%h cnt=%0d exp all 0", init_state, aref_cnt, err_flags, err_count);
    end
    rst = 1'b1; tick();
    checks++; if (init_state !== 3'd1) begin errors++; $display("FAIL post_reset_start: got %0d exp 1", init_state); end
  endtask

  task automatic test_saturation();
    do_reset();
    tick();
    strb = 1'b1;
    repeat (300) tick();
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL saturate: got %0d exp 255", err_count); end
    checks++; if (err_flags !== 8'h10) begin errors++; $display("FAIL saturate_flags: got %h exp 10", err_flags); end
    strb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legal_init();
    test_init_cmd();
    test_aref_short();
    test_phase_timeout();
    test_early_done();
    test_wishbone();
    test_rst_idle_and_clear();
    test_reset_mid_aref();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
